// File: rtl/pattern_match_pkg.sv
// Shared types and helpers for the pattern match sequencer.
// Contents: FSM state encoding and the masked-compare function.
package pattern_match_pkg;

    // Widest request word the shared compare helper can handle.
    localparam int PM_MAX_W = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } pm_state_t;

    // 1 when every care bit of data equals the pattern bit.
    // Arguments are 2-state so an unknown bit can never reach the compare.
    function automatic bit f_maskedMatch(
        input bit [PM_MAX_W-1:0] data,
        input bit [PM_MAX_W-1:0] pattern,
        input bit [PM_MAX_W-1:0] mask
    );
        return ~|((data ^ pattern) & mask);
    endfunction

endpackage

// File: rtl/pattern_match_cmp.sv
// Combinational masked compare of one table entry.
// Ports: i_data/i_pattern/i_mask (DATA_W) in, o_match out.
module pattern_match_cmp
    import pattern_match_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic [DATA_W-1:0] i_mask,
    output logic              o_match
);

    bit [PM_MAX_W-1:0] data_ext;
    bit [PM_MAX_W-1:0] pat_ext;
    bit [PM_MAX_W-1:0] mask_ext;

    // Zero-extend into the helper's fixed width; upper mask bits are 0
    // so the padding never affects the result.
    always_comb begin
        data_ext               = '0;
        pat_ext                = '0;
        mask_ext               = '0;
        data_ext[DATA_W-1:0]   = i_data;
        pat_ext[DATA_W-1:0]    = i_pattern;
        mask_ext[DATA_W-1:0]   = i_mask;
        o_match                = f_maskedMatch(data_ext, pat_ext, mask_ext);
    end

endmodule

// File: rtl/pattern_match_sequencer.sv
// Scans a constant pattern/mask table one entry per cycle through a single
// shared compare and reports the lowest matching index.
// Ports: i_clk, i_rst (sync, active-high), i_cg (clock gate),
//   request  i_req_valid/o_req_ready/i_req_data,
//   response o_rsp_valid/i_rsp_ready/o_rsp_hit/o_rsp_idx, o_xerr.
// Build option: define PATTERN_MATCH_XCHECK_EN to flag unknown request bits
//   on o_xerr; otherwise o_xerr is tied low.
module pattern_match_sequencer
    import pattern_match_pkg::*;
#(
    parameter int                          DATA_W   = 32,
    parameter int                          N_ENTRY  = 8,
    parameter bit [N_ENTRY-1:0][DATA_W-1:0] PATTERNS = '0,
    parameter bit [N_ENTRY-1:0][DATA_W-1:0] MASKS    = '1,
    localparam int IDX_W = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cg,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_hit,
    output logic [IDX_W-1:0]  o_rsp_idx,
    output logic              o_xerr
);

    if (N_ENTRY < 1) begin : g_bad_depth
        $error("pattern_match_sequencer: N_ENTRY must be >= 1");
    end

    if (DATA_W > PM_MAX_W) begin : g_bad_width
        $error("pattern_match_sequencer: DATA_W exceeds PM_MAX_W");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRY - 1);

    pm_state_t         state_q,   state_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              hit_q,     hit_d;
    logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;
    logic              cmp_match;

    pattern_match_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .i_data    (data_q),
        .i_pattern (PATTERNS[idx_q]),
        .i_mask    (MASKS[idx_q]),
        .o_match   (cmp_match)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        hit_d     = hit_q;
        rsp_idx_d = rsp_idx_q;
        if (i_cg) begin
            unique case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        data_d  = i_req_data;
                        idx_d   = '0;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (cmp_match) begin
                        hit_d     = 1'b1;
                        rsp_idx_d = idx_q;
                        state_d   = RESP;
                    end else if (idx_q == LAST_IDX) begin
                        hit_d     = 1'b0;
                        rsp_idx_d = '0;
                        state_d   = RESP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            hit_q     <= 1'b0;
            rsp_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            hit_q     <= hit_d;
            rsp_idx_q <= rsp_idx_d;
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_hit   = hit_q;
    assign o_rsp_idx   = rsp_idx_q;

`ifdef PATTERN_MATCH_XCHECK_EN
    logic xerr_q, xerr_d;
    logic accept;

    assign accept = i_cg & i_req_valid & (state_q == IDLE);

    // Diagnostic pulse: cleared every cycle, even while gated, so it is
    // exactly one cycle wide.
    always_comb begin
        xerr_d = 1'b0;
        if (accept && $isunknown(i_req_data)) begin
            xerr_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            xerr_q <= 1'b0;
        end else begin
            xerr_q <= xerr_d;
            if (xerr_d) begin
                $error("pattern_match_sequencer: unknown bits in request %h",
                       i_req_data);
            end
        end
    end

    assign o_xerr = xerr_q;
`else
    assign o_xerr = 1'b0;
`endif

endmodule
